div_48x20_unsigned_seq: RTL and testbench
=========================================

Name: div_48x20_unsigned_seq

Overview:
- Sequential unsigned divider; the inverse of the 28x20 registered multiplier.
- Takes a 48-bit product-width dividend and a 20-bit divisor; returns a 28-bit quotient and a 20-bit remainder.
- Iterative restoring division, one quotient bit per clock, start/busy/done handshake.
- Sits beside the multiplier in the DSP benchmark set; used for multiply-then-divide round-trip checks (Y = A*B, then Y / B returns A with remainder 0).

Parameters:
- QW, 28, quotient width (multiplier A width).
- DW, 20, divisor/remainder width (multiplier B width).
- YW, QW+DW (48), dividend width; derived, not overridable.

Ports:
- clock0  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only when busy=0.
- Y  in  [0:YW-1]  dividend; index 0 is MSB (same orientation as multiplier output).
- B  in  [0:DW-1]  divisor; index 0 is MSB.
- Q  out  [0:QW-1]  quotient; index 0 is MSB.
- R  out  [0:DW-1]  remainder; index 0 is MSB.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse; Q/R/dbz/ovf valid.
- dbz  out  1  divide-by-zero flag, held with Q/R.
- ovf  out  1  quotient-overflow flag, held with Q/R.

Behaviour:
- Reset (async assert, any state): Q=0, R=0, busy=0, done=0, dbz=0, ovf=0, state IDLE, iteration counter 0. Any in-flight operation is abandoned; nothing resumes after release.
- States: IDLE, CALC, FIN.
- Accept rule: start=1 and busy=0 at a rising edge (call it t0). Y and B are latched.
- t0, B==0: dbz=1, ovf=0, Q=all ones, R=0. Go to FIN, so done=1 in the cycle after t0 (latency 1). No iteration.
- t0, B!=0 and Y[0:DW-1] >= B (quotient would not fit in QW bits): ovf=1, dbz=0, Q=all ones, R=0. Go to FIN, latency 1. dbz has priority over ovf.
- t0, otherwise: dbz=0, ovf=0. Partial remainder P (DW+1 bits) = Y[0:DW-1]; dividend shift register = Y[DW:YW-1]; counter = 0; busy=1; state CALC.
- CALC, each edge:
  - T = {P[DW-1:0], next dividend bit (MSB first)}.
  - If T >= B: P = T-B and quotient bit = 1; else P = T and quotient bit = 0.
  - Quotient bits shift in MSB first; counter increments.
- After the QW-th step (edge t0+QW):
  - Q = quotient, R = P[DW-1:0].
  - busy=0, state FIN, done=1 in the following cycle.
  - Total latency from start edge to done visible: 28 cycles.
- FIN: done=1 for exactly one cycle, then IDLE. Q/R/flags hold until the next accepted start updates them.
- busy and done are never both 1.
- start while busy=1: ignored; no effect on the in-flight operation.
- start during the done cycle: accepted (busy=0), giving back-to-back operations. done deasserts the next cycle as normal.
- Y/B changes after t0 have no effect (operands latched).
- Invariant for a normal completion: Q*B + R == Y, and R < B.

Decomposition:
- Shared defines include (dsp_bm_defines style): QW/DW defaults and state encodings IDLE=2'd0, CALC=2'd1, FIN=2'd2.
- One combinational sub-module, div_restoring_step: inputs P, next bit, B; outputs next P and quotient bit. The top level holds the FSM, counter and registers.

Test Plan:
- Y=0xFFFF_EFF0_0001, B=0xFFFFF -> Q=0xFFFFFFF, R=0, dbz=0, ovf=0; done exactly 28 cycles after the start edge; busy high for 28 cycles.
- Y=1000, B=7 -> Q=142, R=6. Then round-trip: multiplier 0x1234567 x 0xABCDE, feed its product back with B=0xABCDE -> Q=0x1234567, R=0.
- Y=12345, B=0 -> dbz=1, ovf=0, Q=0xFFFFFFF, R=0, done one cycle after start, busy never asserted.
- Y=0x0001_0000_0000, B=0x00010 -> ovf=1, Q=0xFFFFFFF, R=0, latency 1. Repeat with B=0x00011 -> ovf=0, Q=0xF0F0F0F, R=0x1.
- Reset pulse asserted mid-CALC at cycle 10 -> all outputs 0 immediately (async); after release, start with Y=100, B=10 -> Q=10, R=0 after 28 cycles.
- start held high continuously with Y=1000, B=7, then Y=99, B=4 presented at the done cycle -> first op ignores mid-op starts; second accepted in the done cycle giving Q=24, R=3 twenty-eight cycles later.

Source files
------------

// File: rtl/div_48x20_unsigned_seq_pkg.sv
// Shared widths and FSM encoding for the sequential 48/20 unsigned divider.
package div_48x20_unsigned_seq_pkg;

  localparam int unsigned DEF_QW = 28;
  localparam int unsigned DEF_DW = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_restoring_step #(
  parameter int unsigned DW = 20
) (
  input  logic [DW-1:0] p_i,
  input  logic          bit_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] p_next_c,
  output logic          q_bit_c
);

  logic [DW:0] t;

  always_comb begin
    t        = {p_i, bit_i};
    q_bit_c  = (t >= {1'b0, b_i});
    p_next_c = q_bit_c ? DW'(t - {1'b0, b_i}) : t[DW-1:0];
  end

endmodule

// File: rtl/div_48x20_unsigned_seq.sv
// Iterative restoring divider: 48-bit dividend by 20-bit divisor, one quotient bit per clock,
// with start/busy/done handshake and divide-by-zero / quotient-overflow flags.
module div_48x20_unsigned_seq
  import div_48x20_unsigned_seq_pkg::*;
#(
  parameter int unsigned QW = DEF_QW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             start,
  input  logic [0:QW+DW-1] Y,
  input  logic [0:DW-1]    B,
  output logic [0:QW-1]    Q,
  output logic [0:DW-1]    R,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int unsigned YW = QW + DW;
  localparam int unsigned CW = $clog2(QW + 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] p_q, p_d;
  logic [DW-1:0] b_q, b_d;
  logic [QW-1:0] sh_q, sh_d;
  logic [QW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [YW-1:0] y_v;
  logic [DW-1:0] b_v;
  logic [DW-1:0] y_hi;
  logic [QW-1:0] y_lo;
  logic [DW-1:0] step_p;
  logic          step_q;

  // Index 0 of the ports is the MSB; re-express as descending vectors.
  assign y_v  = Y;
  assign b_v  = B;
  assign y_hi = y_v[YW-1 -: DW];
  assign y_lo = y_v[QW-1:0];

  // sh_q holds the unconsumed dividend bits and collects quotient bits at its LSB.
  div_restoring_step #(
    .DW(DW)
  ) u_step (
    .p_i      (p_q),
    .bit_i    (sh_q[QW-1]),
    .b_i      (b_q),
    .p_next_c (step_p),
    .q_bit_c  (step_q)
  );

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    b_d     = b_q;
    sh_d    = sh_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          b_d = b_v;
          // Divide-by-zero outranks overflow; both finish without iterating.
          if (b_v == '0) begin
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            q_d     = '1;
            r_d     = '0;
            done_d  = 1'b1;
            state_d = FIN;
          end else if (y_hi >= b_v) begin
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            p_d     = y_hi;
            sh_d    = y_lo;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        p_d   = step_p;
        sh_d  = {sh_q[QW-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) begin
          q_d     = {sh_q[QW-2:0], step_q};
          r_d     = step_p;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_div_48x20_unsigned_seq.sv
// Bench for div_48x20_unsigned_seq: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and timing.
module tb_div_48x20_unsigned_seq;

  localparam int unsigned QW = 28;
  localparam int unsigned DW = 20;
  localparam int unsigned YW = QW + DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [0:YW-1] y_in;
  logic [0:DW-1] b_in;
  logic [0:QW-1] q_o;
  logic [0:DW-1] r_o;
  logic          busy_o;
  logic          done_o;
  logic          dbz_o;
  logic          ovf_o;

  int n_vec = 0;
  int n_bad = 0;

  div_48x20_unsigned_seq dut (
    .clock0 (clk),
    .reset  (rst),
    .start  (start),
    .Y      (y_in),
    .B      (b_in),
    .Q      (q_o),
    .R      (r_o),
    .busy   (busy_o),
    .done   (done_o),
    .dbz    (dbz_o),
    .ovf    (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: results from plain division, timing as "busy for QW cycles".
  int        m_left = 0;
  bit        m_done = 1'b0;
  bit        m_dbz  = 1'b0;
  bit        m_ovf  = 1'b0;
  bit [63:0] m_q    = '0;
  bit [63:0] m_r    = '0;
  bit [63:0] pend_q = '0;
  bit [63:0] pend_r = '0;

  always @(posedge clk or posedge rst) begin
    logic [63:0] yv;
    logic [63:0] bv;
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_ovf  = 1'b0;
      m_q    = '0;
      m_r    = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_q    = pend_q;
          m_r    = pend_r;
          m_done = 1'b1;
        end
      end else if (start) begin
        yv = 64'(y_in);
        bv = 64'(b_in);
        if (bv == 64'd0) begin
          m_dbz = 1'b1; m_ovf = 1'b0;
          m_q = (64'd1 << QW) - 64'd1; m_r = '0; m_done = 1'b1;
        end else if ((yv >> QW) >= bv) begin
          m_dbz = 1'b0; m_ovf = 1'b1;
          m_q = (64'd1 << QW) - 64'd1; m_r = '0; m_done = 1'b1;
        end else begin
          m_dbz  = 1'b0; m_ovf = 1'b0;
          pend_q = yv / bv;
          pend_r = yv % bv;
          m_left = QW;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [63:0] act;
    logic [63:0] exp;
    act = 64'({busy_o, done_o, dbz_o, ovf_o, q_o, r_o});
    exp = 64'({(m_left > 0), m_done, m_dbz, m_ovf, m_q[QW-1:0], m_r[DW-1:0]});
    check("cycle_outputs", act, exp);
  end

  // Called at the first falling edge after the accept edge; k = edge offset of done.
  task automatic wait_done(output int k, output int nb, output bit seen);
    k = 0; nb = 0; seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) nb++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string nm, input logic [63:0] y, input logic [63:0] b,
                       input logic [63:0] eq, input logic [63:0] er,
                       input bit edbz, input bit eovf, input int ek, input int enb);
    int k;
    int nb;
    bit seen;
    @(negedge clk);
    y_in = YW'(y); b_in = DW'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0; y_in = ~y_in; b_in = ~b_in;
    wait_done(k, nb, seen);
    check({nm, "_done_seen"}, 64'(seen), 64'd1);
    check({nm, "_done_edge"}, 64'(k), 64'(ek));
    check({nm, "_busy_cycles"}, 64'(nb), 64'(enb));
    check({nm, "_q"}, 64'(q_o), eq);
    check({nm, "_r"}, 64'(r_o), er);
    check({nm, "_dbz"}, 64'(dbz_o), 64'(edbz));
    check({nm, "_ovf"}, 64'(ovf_o), 64'(eovf));
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_q"}, 64'(q_o), 64'd0);
    check({nm, "_r"}, 64'(r_o), 64'd0);
    check({nm, "_busy"}, 64'(busy_o), 64'd0);
    check({nm, "_done"}, 64'(done_o), 64'd0);
    check({nm, "_dbz"}, 64'(dbz_o), 64'd0);
    check({nm, "_ovf"}, 64'(ovf_o), 64'd0);
  endtask

  initial begin
    int k;
    int nb;
    bit seen;
    logic [63:0] prod;

    rst = 1'b1; start = 1'b0; y_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    do_op("full", 64'hFFFF_EFF0_0001, 64'hFFFFF, 64'hFFFFFFF, 64'h0, 1'b0, 1'b0, 28, 28);
    do_op("d1000_7", 64'd1000, 64'd7, 64'd142, 64'd6, 1'b0, 1'b0, 28, 28);
    prod = 64'h1234567 * 64'hABCDE;
    do_op("roundtrip", prod, 64'hABCDE, 64'h1234567, 64'h0, 1'b0, 1'b0, 28, 28);
    do_op("dbz", 64'd12345, 64'd0, 64'hFFFFFFF, 64'h0, 1'b1, 1'b0, 0, 0);
    do_op("ovf", 64'h0001_0000_0000, 64'h10, 64'hFFFFFFF, 64'h0, 1'b0, 1'b1, 0, 0);
    do_op("no_ovf", 64'h0001_0000_0000, 64'h11, 64'hF0F0F0F, 64'h1, 1'b0, 1'b0, 28, 28);

    // Abandon an operation with an asynchronous reset mid-iteration.
    @(negedge clk);
    y_in = YW'(64'd1000); b_in = DW'(64'd7); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midreset_busy_before", 64'(busy_o), 64'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op("after_reset", 64'd100, 64'd10, 64'd10, 64'd0, 1'b0, 1'b0, 28, 28);

    // start held high: mid-op starts ignored, new operands accepted in the done cycle.
    @(negedge clk);
    y_in = YW'(64'd1000); b_in = DW'(64'd7); start = 1'b1;
    @(negedge clk);
    wait_done(k, nb, seen);
    check("held1_done_seen", 64'(seen), 64'd1);
    check("held1_done_edge", 64'(k), 64'd28);
    check("held1_q", 64'(q_o), 64'd142);
    check("held1_r", 64'(r_o), 64'd6);
    y_in = YW'(64'd99); b_in = DW'(64'd4);
    @(negedge clk);
    start = 1'b0;
    check("held2_busy_after_accept", 64'(busy_o), 64'd1);
    wait_done(k, nb, seen);
    check("held2_done_seen", 64'(seen), 64'd1);
    check("held2_done_edge", 64'(k), 64'd28);
    check("held2_q", 64'(q_o), 64'd24);
    check("held2_r", 64'(r_o), 64'd3);

    repeat (3) @(negedge clk);
    check("hold_q_after_idle", 64'(q_o), 64'd24);
    check("hold_r_after_idle", 64'(r_o), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
